// File: rtl/logic_tile_cluster_if.sv
// rtl/logic_tile_cluster_if.sv - channel, LE enable and serial-configuration signals of one logic tile
interface logic_tile_cluster_if #(
  parameter int WIDTH = 2
) ();
  logic             enable;
  logic [WIDTH-1:0] data_north_in;
  logic [WIDTH-1:0] data_east_in;
  logic [WIDTH-1:0] data_south_in;
  logic [WIDTH-1:0] data_west_in;
  logic [WIDTH-1:0] data_north_out;
  logic [WIDTH-1:0] data_east_out;
  logic [WIDTH-1:0] data_south_out;
  logic [WIDTH-1:0] data_west_out;
  logic             config_in;
  logic             config_valid;
  logic             config_restart;
  logic             config_out;
  logic             config_loaded;
  logic             config_commit;

  modport master (
    output enable, data_north_in, data_east_in, data_south_in, data_west_in,
    output config_in, config_valid, config_restart,
    input  data_north_out, data_east_out, data_south_out, data_west_out,
    input  config_out, config_loaded, config_commit
  );

  modport slave (
    input  enable, data_north_in, data_east_in, data_south_in, data_west_in,
    input  config_in, config_valid, config_restart,
    output data_north_out, data_east_out, data_south_out, data_west_out,
    output config_out, config_loaded, config_commit
  );
endinterface

// File: rtl/logic_tile_cluster.sv
// rtl/logic_tile_cluster.sv - kfpga tile: switchbox plus LUT logic elements, serial shadow/active configuration
// Optional macro LOGIC_TILE_CONFIG_CHAIN_EN drives config_out from the shadow MSB for daisy-chaining.
module logic_tile_cluster #(
  parameter int WIDTH    = 2,
  parameter int LE_COUNT = 1,
  parameter int LUT_SIZE = 2
) (
  input logic                 clock,
  input logic                 reset,
  logic_tile_cluster_if.slave bus
);
  localparam int LUT_BITS = 1 << LUT_SIZE;
  localparam int LE_BITS  = LUT_BITS + 1;
  localparam int NSRC     = 3 * WIDTH + LE_COUNT;
  localparam int SBW      = $clog2(NSRC);
  localparam int LEW      = $clog2(4 * WIDTH);
  localparam int SB_BASE  = LE_COUNT * LE_BITS;
  localparam int LI_BASE  = SB_BASE + 4 * WIDTH * SBW;
  localparam int CFG_BITS = LI_BASE + LE_COUNT * LUT_SIZE * LEW;
  localparam int CNTW     = $clog2(CFG_BITS);
  localparam int SRC_W    = 1 << SBW;
  localparam int LIN_W    = 1 << LEW;

  typedef enum logic [1:0] {EMPTY, LOADING, COMMIT, ACTIVE} state_t;

  state_t                state, state_next, idle_state;
  logic [CNTW-1:0]       cnt, cnt_next;
  logic [CFG_BITS-1:0]   shadow, active;
  logic                  loaded, commit_q, accept;
  logic [LE_COUNT-1:0]   le_ff, lut_out, le_out;
  logic [3:0][WIDTH-1:0] side_in, side_out;
  logic [LIN_W-1:0]      le_src;

  assign accept = bus.config_valid && !bus.config_restart;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idle_state = loaded ? ACTIVE : EMPTY;
    if (bus.config_restart) begin
      cnt_next   = '0;
      state_next = idle_state;
    end else begin
      if (state == COMMIT) state_next = idle_state;
      // a bit arriving during COMMIT already belongs to the next load
      if (accept) begin
        if (cnt == CNTW'(CFG_BITS - 1)) begin
          cnt_next   = '0;
          state_next = COMMIT;
        end else begin
          cnt_next   = cnt + CNTW'(1);
          state_next = LOADING;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= EMPTY;
      cnt      <= '0;
      shadow   <= '0;
      active   <= '0;
      loaded   <= 1'b0;
      commit_q <= 1'b0;
      le_ff    <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      commit_q <= (state == COMMIT);
      if (accept) shadow <= {shadow[CFG_BITS-2:0], bus.config_in};
      if (state == COMMIT) begin
        active <= shadow;
        loaded <= 1'b1;
      end
      if (bus.enable && loaded) le_ff <= lut_out;
    end
  end

  assign side_in = {bus.data_west_in, bus.data_south_in, bus.data_east_in, bus.data_north_in};
  assign le_src  = LIN_W'(side_in);

  for (genvar i = 0; i < LE_COUNT; i++) begin : g_le
    logic [LUT_SIZE-1:0] sel_in;
    logic [LUT_BITS-1:0] lut;
    for (genvar k = 0; k < LUT_SIZE; k++) begin : g_in
      assign sel_in[k] = le_src[active[LI_BASE + (i * LUT_SIZE + k) * LEW +: LEW]];
    end
    assign lut        = active[i * LE_BITS +: LUT_BITS];
    assign lut_out[i] = lut[sel_in];
    assign le_out[i]  = active[i * LE_BITS + LUT_BITS] ? le_ff[i] : lut_out[i];
  end

  // source list per side: the other three sides in N,E,S,W order, then LE outputs, zero-padded
  for (genvar s = 0; s < 4; s++) begin : g_side
    logic [3*WIDTH-1:0] others;
    logic [SRC_W-1:0]   src;
    for (genvar t = 0; t < 4; t++) begin : g_oth
      if (t != s) begin : g_use
        assign others[(t < s ? t : t - 1) * WIDTH +: WIDTH] = side_in[t];
      end
    end
    assign src = SRC_W'({le_out, others});
    for (genvar j = 0; j < WIDTH; j++) begin : g_bit
      assign side_out[s][j] = loaded & src[active[SB_BASE + (s * WIDTH + j) * SBW +: SBW]];
    end
  end

  assign bus.data_north_out = side_out[0];
  assign bus.data_east_out  = side_out[1];
  assign bus.data_south_out = side_out[2];
  assign bus.data_west_out  = side_out[3];
  assign bus.config_loaded  = loaded;
  assign bus.config_commit  = commit_q;

`ifdef LOGIC_TILE_CONFIG_CHAIN_EN
  assign bus.config_out = shadow[CFG_BITS-1];
`else
  assign bus.config_out = 1'b0;
`endif
endmodule

// File: tb/tb_logic_tile_cluster.sv
// tb/tb_logic_tile_cluster.sv - randomized scoreboard bench for logic_tile_cluster with a behavioural tile model
module tb_logic_tile_cluster;
  localparam int W = 2, LEC = 1, K = 2;
  localparam int LUTB = 1 << K, LEB = LUTB + 1;
  localparam int SBW = 3, LEW = 3;
  localparam int SB_BASE = LEC * LEB;
  localparam int LI_BASE = SB_BASE + 4 * W * SBW;
  localparam int CB = LI_BASE + LEC * K * LEW;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic_tile_cluster_if #(.WIDTH(W)) tif ();
  logic_tile_cluster #(.WIDTH(W), .LE_COUNT(LEC), .LUT_SIZE(K)) dut (
    .clock(clock), .reset(reset), .bus(tif)
  );

  typedef struct packed {
    logic [W-1:0] n, e, s, w;
    logic c, l, o;
  } exp_t;

  exp_t sb[$];
  int tests = 0, failed = 0, cyc = 0, dut_commits = 0, commit_cyc = -1, last_full = -100;

  // model state: accepted-bit history, load progress, committed word
  bit          hist[$];
  int          since;
  bit          pend, m_loaded, m_commit;
  bit [CB-1:0] pend_word, act;
  bit          m_ff[LEC];

  logic [W-1:0] d_n, d_e, d_s, d_w;
  logic d_en, d_cv, d_ci, d_cr, d_rst;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic bit in_bit(int idx);
    int side = idx / W, b = idx % W;
    case (side)
      0: return tif.data_north_in[b];
      1: return tif.data_east_in[b];
      2: return tif.data_south_in[b];
      default: return tif.data_west_in[b];
    endcase
  endfunction

  function automatic int get(int lo, int w);
    int v = 0;
    for (int n = 0; n < w; n++) if (act[lo + n]) v += (1 << n);
    return v;
  endfunction

  function automatic bit lut_val(int i);
    int addr = 0;
    for (int k = 0; k < K; k++) begin
      int idx = get(LI_BASE + (i * K + k) * LEW, LEW);
      if (idx < 4 * W && in_bit(idx)) addr += (1 << k);
    end
    return act[i * LEB + addr];
  endfunction

  function automatic bit le_val(int i);
    return act[i * LEB + LUTB] ? m_ff[i] : lut_val(i);
  endfunction

  function automatic bit side_val(int s, int j);
    bit src[$];
    int idx;
    if (!m_loaded) return 1'b0;
    for (int t = 0; t < 4; t++)
      if (t != s) for (int b = 0; b < W; b++) src.push_back(in_bit(t * W + b));
    for (int i = 0; i < LEC; i++) src.push_back(le_val(i));
    idx = get(SB_BASE + (s * W + j) * SBW, SBW);
    return (idx < src.size()) ? src[idx] : 1'b0;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    for (int j = 0; j < W; j++) begin
      e.n[j] = side_val(0, j);
      e.e[j] = side_val(1, j);
      e.s[j] = side_val(2, j);
      e.w[j] = side_val(3, j);
    end
    e.c = m_commit;
    e.l = m_loaded;
`ifdef LOGIC_TILE_CONFIG_CHAIN_EN
    e.o = (hist.size() == CB) ? hist[0] : 1'b0;
`else
    e.o = 1'b0;
`endif
    return e;
  endfunction

  function automatic void model_edge();
    if (reset) begin
      hist.delete();
      since = 0; pend = 0; act = '0; m_loaded = 0; m_commit = 0;
      for (int i = 0; i < LEC; i++) m_ff[i] = 0;
      return;
    end
    for (int i = 0; i < LEC; i++) if (tif.enable && m_loaded) m_ff[i] = lut_val(i);
    m_commit = pend;
    if (pend) begin
      act = pend_word; m_loaded = 1; pend = 0;
    end
    if (tif.config_restart) since = 0;
    else if (tif.config_valid) begin
      hist.push_back(tif.config_in);
      if (hist.size() > CB) void'(hist.pop_front());
      since++;
      if (since == CB) begin
        for (int n = 0; n < CB; n++) pend_word[CB - 1 - n] = hist[n];
        pend = 1; since = 0; last_full = cyc;
      end
    end
  endfunction

  task automatic step();
    @(posedge clock);
    cyc++;
    model_edge();
    #1;
    reset = d_rst;
    tif.enable = d_en;
    tif.data_north_in = d_n; tif.data_east_in = d_e;
    tif.data_south_in = d_s; tif.data_west_in = d_w;
    tif.config_valid = d_cv; tif.config_in = d_ci; tif.config_restart = d_cr;
    sb.push_back(expect_now());
  endtask

  task automatic shift_bits(input logic [CB-1:0] word, input int count);
    for (int b = CB - 1; b >= CB - count; b--) begin
      d_cv = 1'b1; d_ci = word[b];
      step();
    end
    d_cv = 1'b0;
  endtask

  function automatic logic [CB-1:0] mk(logic [LUTB-1:0] lut, bit ff, int sbs[8], int lis[2]);
    logic [CB-1:0] w = '0;
    w[LUTB-1:0] = lut;
    w[LUTB] = ff;
    for (int m = 0; m < 8; m++) w[SB_BASE + m * SBW +: SBW] = SBW'(sbs[m]);
    for (int m = 0; m < 2; m++) w[LI_BASE + m * LEW +: LEW] = LEW'(lis[m]);
    return w;
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("north_out", tif.data_north_out, e.n);
        chk("east_out", tif.data_east_out, e.e);
        chk("south_out", tif.data_south_out, e.s);
        chk("west_out", tif.data_west_out, e.w);
        chk("config_commit", tif.config_commit, e.c);
        chk("config_loaded", tif.config_loaded, e.l);
        chk("config_out", tif.config_out, e.o);
        if (tif.config_commit === 1'b1) begin
          dut_commits++;
          commit_cyc = cyc;
        end
      end
    end
  end

  initial begin
    logic [CB-1:0] route_cfg, le_cfg;
    logic [70:1]   bits;
    int c0;
    route_cfg = mk(4'b0000, 0, '{7, 7, 4, 7, 7, 7, 7, 7}, '{0, 0});
    le_cfg    = mk(4'b1000, 1, '{7, 7, 7, 7, 6, 7, 7, 7}, '{0, 1});
    d_n = '0; d_e = '0; d_s = '0; d_w = '0;
    d_en = 0; d_cv = 0; d_ci = 0; d_cr = 0; d_rst = 1;
    reset = 1; tif.enable = 0;
    tif.data_north_in = '0; tif.data_east_in = '0; tif.data_south_in = '0; tif.data_west_in = '0;
    tif.config_valid = 0; tif.config_in = 0; tif.config_restart = 0;
    step(); step();
    d_rst = 0;
    step();
    @(negedge clock);
    chk("reset_loaded", tif.config_loaded, 0);
    chk("reset_east", tif.data_east_out, 0);

    // all inputs high, restart dominates so nothing loads
    d_n = '1; d_e = '1; d_s = '1; d_w = '1;
    d_en = 1; d_cv = 1; d_ci = 1; d_cr = 1;
    repeat (10) step();
    @(negedge clock);
    chk("idle_no_commit", dut_commits, 0);
    chk("idle_loaded", tif.config_loaded, 0);
    chk("idle_south", tif.data_south_out, 0);
    d_n = '0; d_e = '0; d_s = '0; d_w = '0;
    d_en = 0; d_cv = 0; d_ci = 0; d_cr = 0;
    step();

    c0 = dut_commits;
    shift_bits(route_cfg, CB);
    repeat (3) step();
    chk("route_commits", dut_commits - c0, 1);
    chk("route_latency", commit_cyc - last_full, 1);
    for (int v = 0; v < 4; v++) begin
      d_w = W'(v);
      step();
      @(negedge clock);
      chk("route_follow", tif.data_east_out[0], v % 2);
    end

    shift_bits(le_cfg, CB);
    repeat (3) step();
    d_n = 2'b11; d_en = 1;
    step(); step();
    @(negedge clock);
    chk("and_registered", tif.data_south_out[0], 1);
    d_n = 2'b00; d_en = 0;
    step(); step();
    @(negedge clock);
    chk("and_hold", tif.data_south_out[0], 1);
    d_en = 1; d_n = 2'b01;
    step(); step();
    @(negedge clock);
    chk("and_clear", tif.data_south_out[0], 0);

    // partial load then restart; old behaviour stays until the new commit
    d_n = 2'b11; d_w = 2'b01;
    c0 = dut_commits;
    shift_bits(route_cfg, 20);
    @(negedge clock);
    chk("partial_keeps_old", tif.data_south_out[0], 1);
    d_cr = 1; step(); d_cr = 0;
    shift_bits(route_cfg, CB);
    @(negedge clock);
    chk("full_before_commit", tif.data_east_out[0], 0);
    repeat (3) step();
    @(negedge clock);
    chk("restart_commits", dut_commits - c0, 1);
    chk("new_route", tif.data_east_out[0], 1);
    chk("new_south", tif.data_south_out[0], 0);

    // reset coincides with the final bit
    c0 = dut_commits;
    d_w = 2'b11;
    shift_bits(le_cfg, CB - 1);
    d_cv = 1; d_ci = le_cfg[0]; d_rst = 1;
    step();
    d_rst = 0; d_cv = 0;
    repeat (4) step();
    @(negedge clock);
    chk("reset_commit_none", dut_commits - c0, 0);
    chk("reset_commit_loaded", tif.config_loaded, 0);
    chk("reset_commit_east", tif.data_east_out, 0);

    for (int k = 1; k <= 70; k++) bits[k] = 1'($urandom);
    for (int k = 1; k <= 70; k++) begin
      d_cv = 1; d_ci = bits[k];
      step();
      @(negedge clock);
`ifdef LOGIC_TILE_CONFIG_CHAIN_EN
      chk("chain_out", tif.config_out, (k > CB) ? 32'(bits[k - CB]) : 0);
`else
      chk("chain_tied", tif.config_out, 0);
`endif
    end
    d_cv = 0;

    repeat (2500) begin
      d_n = W'($urandom); d_e = W'($urandom); d_s = W'($urandom); d_w = W'($urandom);
      d_en = 1'($urandom);
      d_cv = ($urandom_range(0, 2) != 0);
      d_ci = 1'($urandom);
      d_cr = !pend && ($urandom_range(0, 39) == 0);
      d_rst = ($urandom_range(0, 699) == 0);
      step();
    end
    d_cv = 0; d_cr = 0; d_rst = 0;
    repeat (3) step();
    @(negedge clock);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
